// File: rtl/markov_song_generator_pkg.sv
// Shared build constants, state encoding and width helpers for the Markov song generator.
package markov_song_generator_pkg;

    localparam int NOTE_BIT_LEN     = 5;
    localparam int DELAY_BIT_LEN    = 3;
    localparam int SEQUENCE_LEN     = 2;
    localparam int SEQ_CNT_BIT_LEN  = 4;
    localparam int MARKOV_CHAIN_LEN = 4;
    localparam int SONG_OUTPUT_LEN  = 8;

    localparam int EV_W  = NOTE_BIT_LEN + DELAY_BIT_LEN;
    localparam int ENT_W = SEQUENCE_LEN * EV_W + SEQ_CNT_BIT_LEN;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SUM,
        DRAW,
        SELECT,
        EMIT,
        FINISH
    } state_e;

    function automatic int ev_width(input int note_len, input int delay_len);
        return note_len + delay_len;
    endfunction

    function automatic int ent_width(input int seq_len, input int ev_w, input int cnt_len);
        return seq_len * ev_w + cnt_len;
    endfunction

    // Keeps index registers at least one bit wide for a single-entry table.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/markov_song_generator_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting right with feedback into the MSB.
module markov_lfsr16
    import markov_song_generator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d   = lfsr_q;
        // An all-zero seed would lock the register, so it maps to the default.
        if (load) begin
            lfsr_d = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        end else if (advance) begin
            lfsr_d = {feedback, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/markov_song_generator.sv
// Walks a trained Markov table, drawing each next event in proportion to its count.
// state  | meaning
// IDLE   | waiting for start
// SEED   | find first nonzero-count entry, take its context
// SUM    | total the counts of entries matching the context
// DRAW   | r = (lfsr*total)>>16, advance LFSR
// SELECT | pick the entry whose running sum first exceeds r
// EMIT   | present the event until note_ready
// FINISH | done held, error kept, restartable
module markov_song_generator
    import markov_song_generator_pkg::*;
#(
    parameter int NOTE_BIT_LEN     = markov_song_generator_pkg::NOTE_BIT_LEN,
    parameter int DELAY_BIT_LEN    = markov_song_generator_pkg::DELAY_BIT_LEN,
    parameter int SEQUENCE_LEN     = markov_song_generator_pkg::SEQUENCE_LEN,
    parameter int SEQ_CNT_BIT_LEN  = markov_song_generator_pkg::SEQ_CNT_BIT_LEN,
    parameter int MARKOV_CHAIN_LEN = markov_song_generator_pkg::MARKOV_CHAIN_LEN,
    parameter int SONG_OUTPUT_LEN  = markov_song_generator_pkg::SONG_OUTPUT_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [(SEQUENCE_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)+SEQ_CNT_BIT_LEN)*MARKOV_CHAIN_LEN-1:0] markov,
    output logic [NOTE_BIT_LEN+DELAY_BIT_LEN-1:0] note_out,
    output logic        note_valid,
    input  logic        note_ready,
    output logic        done,
    output logic        error
);

    localparam int EV_W   = ev_width(NOTE_BIT_LEN, DELAY_BIT_LEN);
    localparam int ENT_W  = ent_width(SEQUENCE_LEN, EV_W, SEQ_CNT_BIT_LEN);
    localparam int CTX_W  = (SEQUENCE_LEN - 1) * EV_W;
    localparam int TOT_W  = SEQ_CNT_BIT_LEN + $clog2(MARKOV_CHAIN_LEN);
    localparam int IDX_W  = idx_width(MARKOV_CHAIN_LEN);
    localparam int EMIT_W = $clog2(SONG_OUTPUT_LEN + 1);
    localparam int PROD_W = 16 + TOT_W;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MARKOV_CHAIN_LEN - 1);
    localparam logic [EMIT_W-1:0] SONG_END = EMIT_W'(SONG_OUTPUT_LEN);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic [TOT_W-1:0]    cum_q, cum_d;
    logic [TOT_W-1:0]    r_q, r_d;
    logic                found_q, found_d;
    logic [CTX_W-1:0]    ctx_q, ctx_d;
    logic [EV_W-1:0]     note_q, note_d;
    logic [EMIT_W-1:0]   emit_q, emit_d;
    logic                error_q, error_d;

    logic                lfsr_load, lfsr_adv;
    logic [15:0]         lfsr_value;

    logic [ENT_W-1:0]           ent;
    logic [SEQ_CNT_BIT_LEN-1:0] ent_cnt;
    logic [CTX_W-1:0]           ent_ctx;
    logic [EV_W-1:0]            ent_succ;
    logic                       ent_match;
    logic [TOT_W-1:0]           ent_add;
    logic [TOT_W-1:0]           sum_next;
    logic [TOT_W-1:0]           cum_next;
    logic [PROD_W-1:0]          prod;
    logic [TOT_W-1:0]           r_draw;

    markov_lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (seed),
        .advance (lfsr_adv),
        .value   (lfsr_value)
    );

    // Entry layout, LSB first: count, context events (oldest lowest), successor.
    assign ent       = markov[int'(idx_q)*ENT_W +: ENT_W];
    assign ent_cnt   = ent[SEQ_CNT_BIT_LEN-1:0];
    assign ent_ctx   = ent[SEQ_CNT_BIT_LEN +: CTX_W];
    assign ent_succ  = ent[SEQ_CNT_BIT_LEN+CTX_W +: EV_W];
    assign ent_match = (ent_ctx == ctx_q);
    assign ent_add   = ent_match ? TOT_W'(ent_cnt) : '0;
    assign sum_next  = total_q + ent_add;
    assign cum_next  = cum_q + ent_add;

    // Scaling by total keeps r strictly below total without a divider.
    assign prod   = PROD_W'(lfsr_value) * PROD_W'(total_q);
    assign r_draw = TOT_W'(prod >> 16);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        total_d   = total_q;
        cum_d     = cum_q;
        r_d       = r_q;
        found_d   = found_q;
        ctx_d     = ctx_q;
        note_d    = note_q;
        emit_d    = emit_q;
        error_d   = error_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    emit_d    = '0;
                    error_d   = 1'b0;
                    idx_d     = '0;
                    state_d   = SEED;
                end
            end
            SEED: begin
                if (ent_cnt != '0) begin
                    ctx_d   = ent_ctx;
                    idx_d   = '0;
                    total_d = '0;
                    state_d = SUM;
                end else if (idx_q == LAST_IDX) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SUM: begin
                total_d = sum_next;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = (sum_next == '0) ? SEED : DRAW;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAW: begin
                r_d      = r_draw;
                lfsr_adv = 1'b1;
                idx_d    = '0;
                cum_d    = '0;
                found_d  = 1'b0;
                state_d  = SELECT;
            end
            SELECT: begin
                // Full scan regardless of the hit keeps the emit latency fixed.
                cum_d = cum_next;
                if (ent_match && !found_q && (cum_next > r_q)) begin
                    note_d  = ent_succ;
                    found_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = EMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            EMIT: begin
                if (note_ready) begin
                    ctx_d   = (ctx_q >> EV_W) | (CTX_W'(note_q) << (CTX_W - EV_W));
                    emit_d  = emit_q + 1'b1;
                    idx_d   = '0;
                    total_d = '0;
                    state_d = (emit_d == SONG_END) ? FINISH : SUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            total_q <= '0;
            cum_q   <= '0;
            r_q     <= '0;
            found_q <= 1'b0;
            ctx_q   <= '0;
            note_q  <= '0;
            emit_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            cum_q   <= cum_d;
            r_q     <= r_d;
            found_q <= found_d;
            ctx_q   <= ctx_d;
            note_q  <= note_d;
            emit_q  <= emit_d;
            error_q <= error_d;
        end
    end

    assign note_out   = note_q;
    assign note_valid = (state_q == EMIT);
    assign done       = (state_q == FINISH);
    assign error      = error_q;

endmodule

// File: doc/markov_song_generator.md
MARKOV_SONG_GENERATOR -- requirements
Module: markov_song_generator

Interface
REQ-001 SHALL have parameters taken from the shared defines: NOTE_BIT_LEN, DELAY_BIT_LEN, SEQUENCE_LEN (>=2), SEQ_CNT_BIT_LEN, MARKOV_CHAIN_LEN, SONG_OUTPUT_LEN.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or FINISH.
- seed  in  16  LFSR seed, sampled on an accepted start.
- markov  in  (SEQUENCE_LEN*EV_W+SEQ_CNT_BIT_LEN)*MARKOV_CHAIN_LEN  trained table; held stable from start until done.
- note_out  out  EV_W  generated event {note, delay}, with the note in the MSBs.
- note_valid  out  1  note_out is valid.
- note_ready  in  1  consumer accepts the event.
- done  out  1  level; generation finished.
- error  out  1  level; the table has no nonzero-count entry.
REQ-003 EV_W SHALL equal NOTE_BIT_LEN+DELAY_BIT_LEN.
REQ-004 Entry i SHALL occupy markov bits [(i+1)*ENT_W-1 : i*ENT_W].
- Count is in the entry LSBs.
- Event k sits above the count; event 0 is the lowest event.
- Events 0..SEQUENCE_LEN-2 form the context; event SEQUENCE_LEN-1 is the successor.

Function
REQ-005 The state machine SHALL have the states IDLE, SEED, SUM, DRAW, SELECT, EMIT, FINISH.
REQ-006 On start, the block SHALL load the LFSR with seed; seed 0 SHALL be replaced by 16'hACE1. It SHALL then clear the emit counter, clear done and error, and go to SEED.
REQ-007 SEED SHALL scan entries 0..MARKOV_CHAIN_LEN-1, one per cycle.
- Context = context events of the lowest-index entry with a nonzero count; then go to SUM.
- If no such entry exists: set error=1 and go to FINISH.
REQ-008 SUM SHALL scan all entries, one per cycle. Each entry whose context equals the current context adds its count to total.
- Total width: SEQ_CNT_BIT_LEN+clog2(MARKOV_CHAIN_LEN); no overflow is possible.
REQ-009 After SUM, if total==0 (dead end), the block SHALL return to SEED without emitting and without consuming an output slot.
REQ-010 DRAW SHALL compute r = (lfsr*total)>>16, so r < total. The LFSR SHALL advance exactly once per DRAW.
- LFSR: Fibonacci, x^16+x^14+x^13+x^11+1.
REQ-011 SELECT SHALL rescan entries in index order, accumulating the counts of matching entries.
- The first matching entry whose cumulative sum exceeds r is chosen.
- Its successor is latched into note_out, and the block goes to EMIT.
REQ-012 EMIT SHALL hold note_valid=1 with note_out stable until note_ready=1.
- On handshake, the context shifts left by one event, with the successor appended as the newest event.
- The emit counter increments.
- If the count reaches SONG_OUTPUT_LEN, go to FINISH; else go to SUM.
REQ-013 note_valid SHALL be 1 only in EMIT. Latency from entering SUM to note_valid SHALL be exactly 2*MARKOV_CHAIN_LEN+1 cycles when there is no dead end.
REQ-014 FINISH SHALL hold done=1 and keep error at its value. A start in FINISH SHALL restart generation per REQ-006.
REQ-015 A start outside IDLE and FINISH SHALL be ignored.
REQ-016 The block SHALL emit exactly SONG_OUTPUT_LEN events per run unless error is set.

Reset
REQ-017 Reset low SHALL immediately force:
- state=IDLE;
- note_valid=0, done=0, error=0, note_out=0;
- lfsr=16'hACE1;
- counters, total and context to 0.
REQ-018 Reset asserted mid-run SHALL abort generation. No further note_valid SHALL occur until a new start.

Structure
REQ-019 The shared defines SHALL hold the following; none are redefined locally:
- NOTE_BIT_LEN, DELAY_BIT_LEN, SEQUENCE_LEN, SEQ_CNT_BIT_LEN, MARKOV_CHAIN_LEN, SONG_OUTPUT_LEN;
- derived EV_W and ENT_W;
- the LFSR default 16'hACE1.
REQ-020 The LFSR SHALL be the sub-module markov_lfsr16, with ports clk, reset, load, seed, advance, value.

Verification
Bench parameters: NOTE=5, DELAY=3, SEQUENCE_LEN=2, CHAIN=4, CNT=4, SONG_OUTPUT_LEN=8. Let A=8'h21, B=8'h42, C=8'h63.
REQ-021 Table {A->A cnt1}, others cnt0, seed 1 -> eight events A, then done=1 and error=0.
REQ-022 Table {A->B, B->C, C->A}, all cnt1 -> output sequence B,C,A,B,C,A,B,C.
REQ-023 Table {A->B cnt1} only -> output B repeated 8 times. Each dead end after B reseeds the context to A with no gap event.
REQ-024 All counts 0 -> error=1 and done=1 within CHAIN+2 cycles; note_valid never 1.
REQ-025 Hold note_ready=0 for 10 cycles during EMIT -> note_valid stays 1 and note_out is unchanged; exactly one event is consumed on release.
REQ-026 Table {A->B cnt3, A->C cnt1}, runs over seeds 1..64 -> the B:C ratio lies in 2.5..3.5. Then assert reset mid-EMIT -> note_valid=0 immediately, state IDLE.
